// File: rtl/qsys_ram_burst_bridge.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM: splits bursts into
// one word access per cycle and rebuilds readdatavalid from the RAM's 1-cycle latency.
module qsys_ram_burst_bridge #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int BE_W      = 4,
   parameter int BURST_W   = 4,
   parameter int MAX_BURST = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [ADDR_W-1:0]  s_address,
   input  logic [BE_W-1:0]    s_byteenable,
   input  logic               s_read,
   input  logic               s_write,
   input  logic [DATA_W-1:0]  s_writedata,
   input  logic [BURST_W-1:0] s_burstcount,
   output logic               s_waitrequest,
   output logic [DATA_W-1:0]  s_readdata,
   output logic               s_readdatavalid,
   output logic [ADDR_W-1:0]  m_address,
   output logic [BE_W-1:0]    m_byteenable,
   output logic               m_chipselect,
   output logic               m_write,
   output logic [DATA_W-1:0]  m_writedata,
   output logic               m_clken,
   input  logic [DATA_W-1:0]  m_readdata
);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, addr_c;
   logic [BURST_W-1:0]  rem_q, rem_d, len;
   logic                rd_pending, rd_issue;
   logic                cs_c, we_c;
   logic [BE_W-1:0]     be_c;
   logic [DATA_W-1:0]   wd_c;

   always_comb begin
      if (s_burstcount == '0)
         len = BURST_W'(1);
      else if (s_burstcount > BURST_W'(MAX_BURST))
         len = BURST_W'(MAX_BURST);
      else
         len = s_burstcount;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         rd_pending <= 1'b0;
      end else begin
         state      <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         rd_pending <= rd_issue;
      end
   end

   always_comb begin
      state_d  = state;
      addr_d   = addr_q;
      rem_d    = rem_q;
      rd_issue = 1'b0;
      addr_c   = addr_q;
      cs_c     = 1'b0;
      we_c     = 1'b0;
      be_c     = '0;
      wd_c     = '0;
      case (state)
         IDLE: begin
            // write beats are passed straight through; a simultaneous read is dropped
            if (s_write) begin
               addr_c = s_address;
               cs_c   = 1'b1;
               we_c   = 1'b1;
               be_c   = s_byteenable;
               wd_c   = s_writedata;
               if (len > BURST_W'(1)) begin
                  addr_d  = s_address + ADDR_W'(1);
                  rem_d   = len - BURST_W'(1);
                  state_d = WR_BURST;
               end
            end else if (s_read) begin
               addr_c   = s_address;
               cs_c     = 1'b1;
               rd_issue = 1'b1;
               if (len > BURST_W'(1)) begin
                  addr_d  = s_address + ADDR_W'(1);
                  rem_d   = len - BURST_W'(1);
                  state_d = RD_BURST;
               end
            end
         end
         WR_BURST: begin
            if (s_write) begin
               cs_c   = 1'b1;
               we_c   = 1'b1;
               be_c   = s_byteenable;
               wd_c   = s_writedata;
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - BURST_W'(1);
               if (rem_q == BURST_W'(1))
                  state_d = IDLE;
            end
         end
         RD_BURST: begin
            cs_c     = 1'b1;
            rd_issue = 1'b1;
            addr_d   = addr_q + ADDR_W'(1);
            rem_d    = rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // reset_n gates the RAM-side pins so they are quiet while reset is held
   assign m_address       = reset_n ? addr_c : '0;
   assign m_chipselect    = reset_n & cs_c;
   assign m_write         = reset_n & we_c;
   assign m_byteenable    = reset_n ? be_c : '0;
   assign m_writedata     = reset_n ? wd_c : '0;
   assign m_clken         = reset_n;
   assign s_waitrequest   = !reset_n || (state == RD_BURST);
   assign s_readdatavalid = rd_pending;
   assign s_readdata      = reset_n ? m_readdata : '0;

endmodule

// File: doc/qsys_ram_burst_bridge.md
Name: qsys_ram_burst_bridge

Overview:
- Avalon-MM burst slave that sits directly upstream of the 1024x32 single-port on-chip RAM (s1 port).
- Accepts burst reads and writes from a pipelined master (CPU data master or DMA) and issues one single-word RAM access per cycle at incrementing addresses.
- Drives the RAM's address/byteenable/chipselect/write/writedata/clken pins.
- Reconstructs s_readdatavalid from the RAM's fixed 1-cycle read latency (registered address, unregistered q).

Parameters:
ADDR_W, 10, word-address width (RAM depth 2^ADDR_W)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
BURST_W, 4, burstcount width
MAX_BURST, 8, largest burst honoured

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_address  in  ADDR_W  burst start word address
s_byteenable  in  BE_W  byte lanes for the current write beat
s_read  in  1  read burst request
s_write  in  1  write beat valid
s_writedata  in  DATA_W  write beat data
s_burstcount  in  BURST_W  beats in burst; sampled on the command cycle only
s_waitrequest  out  1  stall; command or beat not accepted while high
s_readdata  out  DATA_W  read beat data
s_readdatavalid  out  1  s_readdata valid this cycle
m_address  out  ADDR_W  RAM address
m_byteenable  out  BE_W  RAM byteenable
m_chipselect  out  1  RAM access strobe
m_write  out  1  RAM write
m_writedata  out  DATA_W  RAM write data
m_clken  out  1  RAM clock enable
m_readdata  in  DATA_W  RAM read data, valid 1 cycle after address issue

Behaviour:
- Reset state (reset_n low, asynchronous): FSM=IDLE, beat counter=0, address register=0, rd_pending=0.
  - s_waitrequest=1, s_readdatavalid=0, m_chipselect=0, m_write=0, m_clken=0.
  - All other outputs are 0.
- After reset release: m_clken=1 constantly; s_waitrequest=0 in IDLE and WR_BURST, 1 in RD_BURST.
- Effective length L: s_burstcount, except 0 -> 1 and values >MAX_BURST -> MAX_BURST.
- IDLE:
  - s_write=1: beat 0 passes combinationally; m_address=s_address, m_write=m_chipselect=1, m_byteenable/m_writedata from s_.
    - L>1: latch base+1, load remaining=L-1, go WR_BURST.
  - s_read=1 (s_write=0): m_address=s_address, m_chipselect=1, m_write=0.
    - L>1: latch base+1 and remaining=L-1, go RD_BURST.
  - s_read and s_write both high: write wins; read is dropped.
- WR_BURST:
  - Each cycle s_write=1: drive RAM at the latched address, increment address, decrement remaining. remaining==1 -> IDLE.
  - s_write=0: m_chipselect=0, no advance, no timeout.
  - s_read is ignored.
  - s_address and s_burstcount are ignored.
- RD_BURST:
  - One address issued per cycle; s_waitrequest=1.
  - Last address issued -> IDLE.
- Read return:
  - rd_pending is a register set on every read-issue cycle.
  - s_readdatavalid=rd_pending; s_readdata=m_readdata.
  - Latency: command cycle C -> first data at C+1, one beat per cycle, last at C+L.
  - A new command may be accepted in IDLE while the previous burst's final beat returns; ordering is preserved.
- Address arithmetic: modulo 2^ADDR_W; 1023+1 wraps to 0 within a burst.
- Reset mid-burst:
  - Immediate return to reset state; remaining beats are abandoned and pending readdatavalid is cleared.
  - Words already written stay in the RAM.

Test Plan:
- Write burst: address 0x010, burstcount 4, data 0xA0..0xA3, byteenable 0xF, s_write held high -> RAM writes 0x010..0x013 on 4 consecutive cycles, s_waitrequest low throughout. Read burst of 4 from 0x010 -> s_readdatavalid high cycles C+1..C+4 with 0xA0..0xA3.
- Wrap: write burst 3 at 0x3FE -> RAM addresses 0x3FE, 0x3FF, 0x000. Read burst 3 at 0x3FE -> same three words in order.
- Write stall: burst 4 at 0x020, s_write low for 2 cycles after beat 1 -> m_chipselect low for those 2 cycles, remaining beats land at 0x022, 0x023. Partial byteenable 0x3 on beat 0 of 0x12345678 over prior 0xFFFFFFFF -> readback 0xFFFF5678.
- Edge counts:
  - burstcount 0 -> exactly 1 access.
  - burstcount 15 -> exactly 8 accesses.
  - Back-to-back reads of 2 at 0x000 then 2 at 0x100, second command accepted the cycle after RD_BURST ends -> 4 contiguous valid beats, no gap, correct order.
- Collision: s_read and s_write both high in IDLE -> write performed, no s_readdatavalid.
- Reset: reset_n low during cycle 3 of an 8-beat read -> s_readdatavalid drops to 0 the same cycle, s_waitrequest=1 and m_chipselect=0 during reset. After release, a single read returns correct data 1 cycle after the command.
